// File: rtl/calc_pkg.sv
// Shared opcode and FSM state encodings for the token-stream calculator.
// Latency: none, declarations only.
// Backpressure: not applicable.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_MUL = 3'd0,
    OP_ADD = 3'd1,
    OP_SQR = 3'd2,
    OP_INC = 3'd3,
    OP_SUB = 3'd4,
    OP_CLR = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    S_NUM = 2'd0,
    S_OP  = 2'd1,
    S_ARG = 2'd2
  } state_t;

  // Highest legal opcode value; any token above it is rejected in S_OP.
  localparam int OP_LAST = 5;

  // Unary ops complete in S_OP without waiting for a second operand.
  function automatic logic is_unary(input op_t op);
    return (op == OP_SQR) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Unsigned arithmetic core: MUL/ADD/SQR/INC/SUB with overflow/borrow flag.
// Latency: purely combinational.
// Backpressure: none, the caller decides when the result is used.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         ovf
);

  logic [W-1:0]   mul_b;
  logic [2*W-1:0] prod;
  logic [W:0]     sum;

  // SQR reuses the multiplier with the first operand on both inputs.
  assign mul_b = (op == OP_SQR) ? a : b;
  assign prod  = {{W{1'b0}}, a} * {{W{1'b0}}, mul_b};
  assign sum   = {1'b0, a} + {1'b0, b};

  // Select the result and its overflow indication per opcode.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_MUL, OP_SQR: begin
        res = prod[W-1:0];
        ovf = |prod[2*W-1:W];
      end
      OP_ADD: begin
        res = sum[W-1:0];
        ovf = sum[W];
      end
      OP_INC: begin
        res = a + {{(W-1){1'b0}}, 1'b1};
        ovf = &a;
      end
      OP_SUB: begin
        res = a - b;
        ovf = (b > a);
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_stream.sv
// Token-stream calculator: operand/opcode/operand tokens in, one result per operation out.
// Latency: result registered, out_valid rises the cycle after the final token is accepted.
// Backpressure: single result slot; in_ready drops while a result is held and out_ready is low.
module calc_stream
  import calc_pkg::*;
#(
  parameter int W     = 16,
  parameter int CHAIN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         err
);

  // In chained mode a finished result becomes the next A, so skip the operand phase.
  localparam state_t DONE_ST = (CHAIN != 0) ? S_OP : S_NUM;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] a_q;
  op_t          op_q;

  logic         acc;
  logic         legal;
  op_t          tok_op;
  op_t          alu_op;
  logic [W-1:0] alu_res;
  logic         alu_ovf;
  logic         fire;
  logic         ill;
  logic         lat_a;
  logic         lat_op;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  // The whole token is compared so large values never alias onto valid opcodes.
  assign legal    = (in_data <= W'(OP_LAST));
  assign tok_op   = op_t'(in_data[2:0]);
  // Unary ops execute on the opcode token itself; binary ops use the latched opcode.
  assign alu_op   = (state == S_OP) ? tok_op : op_q;

  calc_alu #(.W(W)) u_alu (
    .op  (alu_op),
    .a   (a_q),
    .b   (in_data),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_NUM;
    else     state <= state_nxt;
  end

  // Next-state decode; nothing moves unless a token is accepted.
  always_comb begin
    state_nxt = state;
    if (acc) begin
      case (state)
        S_NUM: state_nxt = S_OP;
        S_OP: begin
          if (legal) begin
            if (tok_op == OP_CLR)     state_nxt = S_NUM;
            else if (is_unary(tok_op)) state_nxt = DONE_ST;
            else                       state_nxt = S_ARG;
          end
        end
        S_ARG:   state_nxt = DONE_ST;
        default: state_nxt = S_NUM;
      endcase
    end
  end

  // Output decode: which registers load on this accepted token.
  always_comb begin
    fire   = 1'b0;
    ill    = 1'b0;
    lat_a  = 1'b0;
    lat_op = 1'b0;
    if (acc) begin
      case (state)
        S_NUM: lat_a = 1'b1;
        S_OP: begin
          if (!legal)                 ill    = 1'b1;
          else if (is_unary(tok_op))  fire   = 1'b1;
          else if (tok_op != OP_CLR)  lat_op = 1'b1;
        end
        S_ARG:   fire = 1'b1;
        default: fire = 1'b0;
      endcase
    end
  end

  // Operand/opcode registers, error pulse and the single output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      op_q      <= OP_MUL;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= ill;
      if (lat_a)                      a_q <= in_data;
      else if (fire && (CHAIN != 0))  a_q <= alu_res;
      if (lat_op) op_q <= tok_op;
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= alu_res;
        out_ovf   <= alu_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_stream.sv
// Randomized scoreboard bench for calc_stream, one plain and one chained instance.
// Latency: expects each result the cycle after its final token is accepted.
// Backpressure: out_ready toggled randomly and held low for a window to exercise the slot.
module tb_calc_stream;

  localparam int W    = 16;
  localparam int NCYC = 2000;
  localparam int AS   = 4096;
  localparam int QS   = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic         out_ovf   [2];
  logic         err       [2];

  always #5 clk = ~clk;

  // Instance 0 runs plain mode, instance 1 runs chained-accumulator mode.
  calc_stream #(.W(W), .CHAIN(0)) u_plain (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_ovf(out_ovf[0]), .err(err[0])
  );

  calc_stream #(.W(W), .CHAIN(1)) u_chain (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_ovf(out_ovf[1]), .err(err[1])
  );

  // Reference model: where we are in the operand/opcode/operand grammar.
  int           phase [2];   // 0 expect operand, 1 expect opcode, 2 expect second operand
  int unsigned  ma    [2];
  int unsigned  mop   [2];
  logic [W:0]   expb  [2][QS];
  int           eh    [2];
  int           et    [2];
  int unsigned  tokb  [2][QS];
  int           th    [2];
  int           tt    [2];
  bit           err_at[2][AS];
  bit           res_at[2][AS];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic         rst_prev = 1'b0;
  bit           hold_prev [2];
  logic [W:0]   held      [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Plain-arithmetic reference for one operation; returns {ovf, result}.
  function automatic logic [W:0] ref_calc(input int unsigned op, input int unsigned a, input int unsigned b);
    longint unsigned m, full, r;
    logic o;
    m    = 64'd1 << W;
    full = 0;
    r    = 0;
    o    = 1'b0;
    case (op)
      0: begin full = longint'(a) * longint'(b); r = full % m; o = (full >= m); end
      1: begin full = longint'(a) + longint'(b); r = full % m; o = (full >= m); end
      2: begin full = longint'(a) * longint'(a); r = full % m; o = (full >= m); end
      3: begin r = (longint'(a) + 1) % m; o = (a == m - 1); end
      default: begin r = (longint'(a) + m - longint'(b)) % m; o = (b > a); end
    endcase
    return {o, r[W-1:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0;
      ma[k]    = 0;
      mop[k]   = 0;
      eh[k]    = et[k];
      th[k]    = tt[k];
    end
  endtask

  task automatic push_tok(input int k, input int unsigned t);
    tokb[k][tt[k] % QS] = t;
    tt[k]++;
  endtask

  // Apply one accepted token to the model and schedule the expected responses.
  task automatic model_token(input int k, input int unsigned tok);
    logic [W:0] r;
    bit done;
    done = 0;
    r    = '0;
    case (phase[k])
      0: begin ma[k] = tok; phase[k] = 1; end
      1: begin
        if (tok > 5)                   err_at[k][cyc + 1] = 1'b1;
        else if (tok == 5)             phase[k] = 0;
        else if (tok == 2 || tok == 3) begin r = ref_calc(tok, ma[k], ma[k]); done = 1; end
        else begin mop[k] = tok; phase[k] = 2; end
      end
      default: begin r = ref_calc(mop[k], ma[k], tok); done = 1; end
    endcase
    if (done) begin
      expb[k][et[k] % QS] = r;
      et[k]++;
      res_at[k][cyc + 1] = 1'b1;
      if (k == 1) begin ma[k] = r[W-1:0]; phase[k] = 1; end
      else phase[k] = 0;
    end
  endtask

  function automatic int unsigned gen_tok(input int k);
    int unsigned r;
    if (phase[k] == 1) begin
      r = $urandom_range(0, 15);
      if (r < 12) return $urandom_range(0, 4);
      if (r < 14) return 5;
      return $urandom_range(6, 65535);
    end
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 3);
      1:       return 65535 - $urandom_range(0, 3);
      2:       return $urandom_range(0, 300);
      default: return $urandom_range(0, 65535);
    endcase
  endfunction

  // Stimulus: drive 1 time unit after each rising edge, decide acceptance 1 unit later.
  initial begin
    int unsigned d0 [] = '{7,0,9, 300,0,300, 65535,1,1, 5,2, 65535,3, 3,4,5,
                           4,9,1,6, 8,5,2,1,9, 7,0};
    int unsigned d1 [] = '{2,1,3,2,3,5,4,1,4};
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
      eh[k] = 0; et[k] = 0; th[k] = 0; tt[k] = 0;
      hold_prev[k] = 0; held[k] = '0;
    end
    model_reset();
    foreach (d0[i]) push_tok(0, d0[i]);
    foreach (d1[i]) push_tok(1, d1[i]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst = (c == 27) || (c == 700) || (c == 1400);
      if (rst) begin
        model_reset();
        if (c == 27) begin push_tok(0, 2); push_tok(0, 3); end
      end
      for (int k = 0; k < 2; k++) begin
        if (th[k] == tt[k]) push_tok(k, gen_tok(k));
        in_data[k]   = tokb[k][th[k] % QS][W-1:0];
        in_valid[k]  = (c < 80) ? 1'b1 : ($urandom_range(0, 3) != 0);
        out_ready[k] = (c < 80) ? 1'b1 : (c < 90) ? 1'b0 : ($urandom_range(0, 9) < 7);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (in_valid[k] && in_ready[k]) begin
          model_token(k, tokb[k][th[k] % QS]);
          th[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("drain", k, et[k] - eh[k], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: mid-cycle, compare outputs with the scoreboard and pop on consume.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_in_ready", k, 32'(in_ready[k]), 0);
        if (rst_prev)
          chk("rst_outputs", k, {out_valid[k], err[k], out_ovf[k], out_data[k]}, 0);
        hold_prev[k] = 0;
      end else begin
        int pend;
        if (rst_prev) chk("post_rst_data", k, {out_ovf[k], out_data[k]}, 0);
        chk("in_ready", k, 32'(in_ready[k]), 32'(!(out_valid[k] && !out_ready[k])));
        chk("err", k, 32'(err[k]), 32'(err_at[k][cyc]));
        pend = et[k] - eh[k] - int'(res_at[k][cyc + 1]);
        chk("out_valid", k, 32'(out_valid[k]), 32'(pend > 0));
        if (hold_prev[k] && out_valid[k])
          chk("hold", k, {out_ovf[k], out_data[k]}, held[k]);
        if (out_valid[k] && eh[k] != et[k]) begin
          chk("result", k, {out_ovf[k], out_data[k]}, expb[k][eh[k] % QS]);
          if (out_ready[k]) eh[k]++;
        end
        hold_prev[k] = out_valid[k] && !out_ready[k];
        held[k]      = {out_ovf[k], out_data[k]};
      end
    end
    rst_prev = rst;
  end

endmodule
